// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
package reg_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // One pending register-file write: destination index plus data.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Which source feeds the output stage in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_FIFO = 2'd1,
        SEL_LSU  = 2'd2,
        SEL_ALU  = 2'd3
    } wb_sel_e;

    // A query matches a pending destination only when it names a real register (x0 is never busy).
    function automatic logic rd_match(input logic [REG_AW-1:0] query, input logic [REG_AW-1:0] rd);
        return (query != '0) && (query == rd);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// ALU result FIFO for the write-back controller. Besides push/pop it exposes
// a per-slot valid bit and destination index so the top can do busy and
// same-destination (WAW) comparisons against everything still queued.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    assign ent_valid = valid_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign ent_rd[gi] = mem_q[gi].rd;
        end
    endgenerate

    // Next-state for pointers, occupancy and slot-valid bits; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (push_ok) begin
            wr_ptr_d          = wr_ptr_q + PW'(1);
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d          = rd_ptr_q + PW'(1);
            valid_d[rd_ptr_q] = 1'b0;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue so nothing stale is ever written back.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage; contents are qualified by valid_q so they need no reset.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Write-back controller for the RV32I register-file write port (RegWr/Rw/busW).
// Merges ALU results (buffered in wb_fifo) and LSU load results into at most
// one registered write per cycle, and reports per-source busy flags.
// Data width comes from reg_wb_pkg::XLEN.
// Optional feature: define REG_WB_BYPASS_EN to let an ALU result skip the FIFO
// and go straight to the output stage when nothing else claims it that cycle.
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              RegWr,
    output logic [REG_AW-1:0] Rw,
    output logic [XLEN-1:0]   busW,
    input  logic [REG_AW-1:0] q_rs1,
    input  logic [REG_AW-1:0] q_rs2,
    output logic              busy_rs1,
    output logic              busy_rs2
);

    wb_entry_t                    head;
    wb_entry_t                    push_entry;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
    logic [DEPTH-1:0]             lsu_hit;
    logic [DEPTH-1:0]             rs1_hit;
    logic [DEPTH-1:0]             rs2_hit;
    logic                         alu_fire;
    logic                         lsu_fire;
    logic                         alu_wr;
    logic                         lsu_wr;
    wb_sel_e                      sel;

    logic              regwr_q, regwr_d;
    logic [REG_AW-1:0] rw_q, rw_d;
    logic [XLEN-1:0]   busw_q, busw_d;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .ent_valid  (ent_valid),
        .ent_rd     (ent_rd)
    );

    // Per-slot comparators: WAW guard for loads and busy lookups for both issue queries.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign lsu_hit[gi] = ent_valid[gi] && (ent_rd[gi] == lsu_rd);
            assign rs1_hit[gi] = ent_valid[gi] && rd_match(q_rs1, ent_rd[gi]);
            assign rs2_hit[gi] = ent_valid[gi] && rd_match(q_rs2, ent_rd[gi]);
        end
    endgenerate

    // A load must wait while an older ALU result to the same register is queued.
    assign alu_ready = !fifo_full;
    assign lsu_ready = !fifo_full && !(|lsu_hit);

    assign alu_fire = alu_valid && alu_ready;
    assign lsu_fire = lsu_valid && lsu_ready;
    // Writes to x0 are accepted but discarded.
    assign alu_wr   = alu_fire && (alu_rd != '0);
    assign lsu_wr   = lsu_fire && (lsu_rd != '0);

    assign push_entry = '{rd: alu_rd, data: alu_data};

    // Output source priority: a full FIFO drains first so loads cannot starve it.
    always_comb begin
        sel = SEL_NONE;
        if (fifo_full) begin
            sel = SEL_FIFO;
        end else if (lsu_wr) begin
            sel = SEL_LSU;
        end else if (!fifo_empty) begin
            sel = SEL_FIFO;
`ifdef REG_WB_BYPASS_EN
        end else if (alu_wr) begin
            sel = SEL_ALU;
`endif
        end
    end

    assign fifo_pop  = (sel == SEL_FIFO);
    assign fifo_push = alu_wr && (sel != SEL_ALU);

    // Output stage next state; Rw/busW hold their last value on idle cycles.
    always_comb begin
        regwr_d = 1'b0;
        rw_d    = rw_q;
        busw_d  = busw_q;
        case (sel)
            SEL_FIFO: begin
                regwr_d = 1'b1;
                rw_d    = head.rd;
                busw_d  = head.data;
            end
            SEL_LSU: begin
                regwr_d = 1'b1;
                rw_d    = lsu_rd;
                busw_d  = lsu_data;
            end
            SEL_ALU: begin
                regwr_d = 1'b1;
                rw_d    = alu_rd;
                busw_d  = alu_data;
            end
            default: ;
        endcase
    end

    // Registered write port; reset drops any staged write.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regwr_q <= 1'b0;
            rw_q    <= '0;
            busw_q  <= '0;
        end else begin
            regwr_q <= regwr_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
        end
    end

    assign RegWr = regwr_q;
    assign Rw    = rw_q;
    assign busW  = busw_q;

    // A source is busy while any queued or staged write targets it.
    assign busy_rs1 = (|rs1_hit) || (regwr_q && rd_match(q_rs1, rw_q));
    assign busy_rs2 = (|rs2_hit) || (regwr_q && rd_match(q_rs2, rw_q));

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed testbench for reg_wb_ctrl.
module tb_reg_wb_ctrl;
    import reg_wb_pkg::*;

`ifdef REG_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              alu_valid, alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid, lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic              RegWr;
    logic [REG_AW-1:0] Rw;
    logic [XLEN-1:0]   busW;
    logic [REG_AW-1:0] q_rs1, q_rs2;
    logic              busy_rs1, busy_rs2;

    int n_assert = 0;
    int n_fail   = 0;

    reg_wb_ctrl #(.DEPTH(4)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .RegWr     (RegWr),
        .Rw        (Rw),
        .busW      (busW),
        .q_rs1     (q_rs1),
        .q_rs2     (q_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [4:0] rw, input logic [31:0] bw);
        $display("[%0t] %s: RegWr=%0d Rw=%0d busW=0x%08h", $time, tag, RegWr, Rw, busW);
        chk({tag, ".RegWr"}, 32'(RegWr), 32'(we));
        chk({tag, ".Rw"},    32'(Rw),    32'(rw));
        chk({tag, ".busW"},  busW,       bw);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = data;
    endtask

    task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data);
        lsu_valid = 1'b1;
        lsu_rd    = rd;
        lsu_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        q_rs1 = '0; q_rs2 = '0;

        // Reset state
        tick(); tick();
        chk_out("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.alu_ready", 32'(alu_ready), 32'd1);
        chk("reset.lsu_ready", 32'(lsu_ready), 32'd1);
        chk("reset.busy_rs1", 32'(busy_rs1), 32'd0);
        chk("reset.busy_rs2", 32'(busy_rs2), 32'd0);
        Rst_n = 1'b1;

        // Single ALU beat x5 = 0x11
        drive_alu(5'd5, 32'h11);
        q_rs1 = 5'd5;
        tick();
        alu_valid = 1'b0;
        chk_out("alu_x5_e1", BYP, BYP ? 5'd5 : 5'd0, BYP ? 32'h11 : 32'h0);
        chk("alu_x5_e1.busy_rs1", 32'(busy_rs1), 32'd1);
        tick();
        chk_out("alu_x5_e2", !BYP, 5'd5, 32'h11);
        chk("alu_x5_e2.busy_rs1", 32'(busy_rs1), 32'(!BYP));

        // ALU write to x0 is accepted and dropped
        drive_alu(5'd0, 32'hFFFF_FFFF);
        q_rs1 = 5'd0;
        #1;
        chk("alu_x0.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        chk_out("alu_x0_e1", 1'b0, 5'd5, 32'h11);
        chk("alu_x0.busy_rs1", 32'(busy_rs1), 32'd0);
        q_rs2 = 5'd5;
        tick();
        chk_out("alu_x0_e2", 1'b0, 5'd5, 32'h11);
        chk("alu_x0.fifo_empty_alu_ready", 32'(alu_ready), 32'd1);
        chk("alu_x0.fifo_empty_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("alu_x0.busy_rs2", 32'(busy_rs2), 32'd0);

        // Fill FIFO with x1..x4 while loads x20..x23 take the output stage
        q_rs1 = 5'd3;
        q_rs2 = 5'd4;
        drive_alu(5'd1, 32'h101); drive_lsu(5'd20, 32'h200);
        #1;
        chk("fill.alu_ready", 32'(alu_ready), 32'd1);
        chk("fill.lsu_ready", 32'(lsu_ready), 32'd1);
        tick();
        chk_out("fill1", 1'b1, 5'd20, 32'h200);
        drive_alu(5'd2, 32'h102); drive_lsu(5'd21, 32'h201);
        tick();
        chk_out("fill2", 1'b1, 5'd21, 32'h201);
        drive_alu(5'd3, 32'h103); drive_lsu(5'd22, 32'h202);
        tick();
        chk_out("fill3", 1'b1, 5'd22, 32'h202);
        chk("fill3.busy_rs1", 32'(busy_rs1), 32'd1);
        drive_alu(5'd4, 32'h104); drive_lsu(5'd23, 32'h203);
        tick();
        chk_out("fill4", 1'b1, 5'd23, 32'h203);
        chk("full.alu_ready", 32'(alu_ready), 32'd0);
        chk("full.busy_rs2", 32'(busy_rs2), 32'd1);
        alu_valid = 1'b0;
        drive_lsu(5'd9, 32'h900);
        #1;
        chk("full.lsu_ready", 32'(lsu_ready), 32'd0);
        tick();
        chk_out("drain_x1", 1'b1, 5'd1, 32'h101);
        chk("drain_x1.lsu_ready", 32'(lsu_ready), 32'd1);
        chk("drain_x1.alu_ready", 32'(alu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk_out("load_x9", 1'b1, 5'd9, 32'h900);
        tick();
        chk_out("drain_x2", 1'b1, 5'd2, 32'h102);
        tick();
        chk_out("drain_x3", 1'b1, 5'd3, 32'h103);
        chk("drain_x3.busy_rs1", 32'(busy_rs1), 32'd1);
        tick();
        chk_out("drain_x4", 1'b1, 5'd4, 32'h104);
        chk("drain_x4.busy_rs1", 32'(busy_rs1), 32'd0);
        chk("drain_x4.busy_rs2", 32'(busy_rs2), 32'd1);
        tick();
        chk_out("drain_idle", 1'b0, 5'd4, 32'h104);
        chk("drain_idle.busy_rs2", 32'(busy_rs2), 32'd0);

        // WAW: queued ALU x7 must be written before a load to x7
        drive_alu(5'd7, 32'h700); drive_lsu(5'd10, 32'hA00);
        tick();
        alu_valid = 1'b0;
        chk_out("waw_load_x10", 1'b1, 5'd10, 32'hA00);
        drive_lsu(5'd7, 32'h777);
        #1;
        chk("waw.lsu_ready_blocked", 32'(lsu_ready), 32'd0);
        tick();
        chk_out("waw_alu_x7", 1'b1, 5'd7, 32'h700);
        chk("waw.lsu_ready_free", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        chk_out("waw_load_x7", 1'b1, 5'd7, 32'h777);
        tick();
        chk_out("waw_idle", 1'b0, 5'd7, 32'h777);

        // Reset mid-stream with three queued entries and a staged write
        drive_alu(5'd11, 32'hB1); drive_lsu(5'd24, 32'h24);
        tick();
        drive_alu(5'd12, 32'hB2); drive_lsu(5'd25, 32'h25);
        tick();
        drive_alu(5'd13, 32'hB3); drive_lsu(5'd26, 32'h26);
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        q_rs1 = 5'd11;
        chk_out("pre_rst", 1'b1, 5'd26, 32'h26);
        #1;
        chk("pre_rst.busy_rs1", 32'(busy_rs1), 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 5'd0, 32'h0);
        chk("mid_rst.busy_rs1", 32'(busy_rs1), 32'd0);
        chk("mid_rst.alu_ready", 32'(alu_ready), 32'd1);
        tick(); tick();
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("post_rst%0d", i), 1'b0, 5'd0, 32'h0);
        end
        chk("post_rst.busy_rs1", 32'(busy_rs1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
